// File: rtl/fb_arbiter_if.sv
// -----------------------------------------------------------------------------
// fb_arbiter_if
//
// Purpose:
//   Bundles every signal around the frame-buffer arbiter: the display
//   controller's read path, the renderer's write/swap handshake and the
//   single RAM port the arbiter owns. clk and rst are not part of the bundle;
//   they stay plain ports on the arbiter.
//
// Parameters:
//   ADDR_W - per-bank word address width (RAM address is ADDR_W+1 bits)
//   DATA_W - RAM word width ([23:12] top-half pixel, [11:0] bottom-half pixel)
//
// Modports:
//   slave  - the arbiter's view (display/renderer/RAM-read inputs in,
//            read data, grants, bank state and RAM controls out)
//   master - the surrounding system's view (exact mirror of slave)
// -----------------------------------------------------------------------------
interface fb_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24
);

   // Display controller (read side)
   logic              disp_re;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;
   logic              frame_end;

   // Renderer (write side)
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_gnt;
   logic              swap_req;
   logic              swap_ack;
   logic              front_bank;

   // Shared single-port RAM (MSB of mem_addr selects the bank)
   logic [ADDR_W:0]   mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  disp_re, disp_addr, frame_end,
      input  wr_req, wr_addr, wr_data, swap_req,
      input  mem_rdata,
      output disp_data, disp_valid,
      output wr_gnt, swap_ack, front_bank,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output disp_re, disp_addr, frame_end,
      output wr_req, wr_addr, wr_data, swap_req,
      output mem_rdata,
      input  disp_data, disp_valid,
      input  wr_gnt, swap_ack, front_bank,
      input  mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/fb_arbiter.sv
// -----------------------------------------------------------------------------
// fb_arbiter
//
// Purpose:
//   Owns the only port of the double-banked frame-buffer RAM and shares it
//   between the LED-matrix display controller (reads the front bank) and the
//   lava renderer (writes the back bank). Swaps front/back banks only at a
//   frame boundary so the panel never shows a half-rendered frame.
//
//   Port priority, highest first:
//     1. display read   -> {front_bank, disp_addr}, mem_we = 0
//     2. renderer write -> {~front_bank, wr_addr},  mem_we = 1 (WRITE state)
//     3. clear write    -> {~front_bank, clr_cnt},  data 0 (CLEAR state)
//     4. idle           -> mem_addr holds its last value, mem_we = 0
//
// Configuration:
//   FB_ARB_CLEAR_EN - when defined, every swap is followed by a CLEAR phase
//                     that zeroes all words of the new back bank, ascending,
//                     one word per port-idle cycle. When undefined, the CLEAR
//                     state and its counter do not exist and back-bank
//                     contents persist across swaps.
//
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   bus  - fb_arbiter_if.slave:
//            disp_re/disp_addr      display read request and address
//            disp_data/disp_valid   read data (1-cycle latency) and its valid
//            frame_end              one-cycle end-of-frame pulse from display
//            wr_req/wr_addr/wr_data renderer write request (level, held)
//            wr_gnt                 write accepted this cycle (combinational)
//            swap_req/swap_ack      back bank finished / swap done pulse
//            front_bank             bank currently being displayed
//            mem_addr/mem_we/mem_wdata/mem_rdata  RAM port (sync read)
// -----------------------------------------------------------------------------
module fb_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 24
) (
   input  logic        clk,
   input  logic        rst,
   fb_arbiter_if.slave bus
);

`ifdef FB_ARB_CLEAR_EN
   typedef enum logic [1:0] {
      ST_WRITE   = 2'd0,
      ST_PENDING = 2'd1,
      ST_CLEAR   = 2'd2
   } state_t;

   // Where the FSM lands right after a bank swap.
   localparam state_t POST_SWAP = ST_CLEAR;
   // Last word of a bank; the clear ends when the counter wraps past it.
   localparam logic [ADDR_W-1:0] CLR_LAST = '1;
`else
   typedef enum logic [1:0] {
      ST_WRITE   = 2'd0,
      ST_PENDING = 2'd1
   } state_t;

   localparam state_t POST_SWAP = ST_WRITE;
`endif

   state_t            state;
   logic              front_bank;
   logic              swap_ack;
   logic              disp_valid;
   logic [ADDR_W:0]   last_addr;

   logic              wr_gnt;
   logic              swap_now;
   logic [ADDR_W:0]   mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;

`ifdef FB_ARB_CLEAR_EN
   logic [ADDR_W-1:0] clr_cnt;
   logic              clr_we;

   // A clear word is written only on cycles the display leaves the port free.
   assign clr_we = (state == ST_CLEAR) & ~bus.disp_re & ~rst;
`endif

   // ---------------------------------------------------------------------------
   // Grant and swap decisions
   // ---------------------------------------------------------------------------

   // The renderer only gets the port in WRITE and only when the display is not
   // reading. A cycle in reset never writes the RAM, so a reset that lands in
   // the middle of a clear stops the RAM writes immediately.
   assign wr_gnt = bus.wr_req & ~bus.disp_re & (state == ST_WRITE) & ~rst;

   // Swap at the edge that samples frame_end: either from PENDING, or directly
   // from WRITE when swap_req and frame_end coincide. swap_req is ignored in
   // the swap_ack cycle so a renderer that drops it in response to the ack is
   // not mistaken for a fresh request.
   assign swap_now = ~rst & bus.frame_end &
                     (((state == ST_WRITE) & bus.swap_req & ~swap_ack) |
                      (state == ST_PENDING));

   // ---------------------------------------------------------------------------
   // RAM port multiplexer
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the block leaves it unassigned and no latch is inferred.
      mem_addr  = last_addr;
      mem_we    = 1'b0;
      mem_wdata = '0;

      if (rst) begin
         mem_addr = '0;
      end else if (bus.disp_re) begin
         // Reads use the bank displayed in the request cycle, so a read issued
         // alongside frame_end still sees the old front bank.
         mem_addr = {front_bank, bus.disp_addr};
      end else if (wr_gnt) begin
         mem_addr  = {~front_bank, bus.wr_addr};
         mem_we    = 1'b1;
         mem_wdata = bus.wr_data;
`ifdef FB_ARB_CLEAR_EN
      end else if (clr_we) begin
         // front_bank has already toggled, so ~front_bank is the new back bank.
         mem_addr = {~front_bank, clr_cnt};
         mem_we   = 1'b1;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // FSM and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: all state here updates with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         state      <= ST_WRITE;
         front_bank <= 1'b0;
         swap_ack   <= 1'b0;
         disp_valid <= 1'b0;
         last_addr  <= '0;
`ifdef FB_ARB_CLEAR_EN
         clr_cnt    <= '0;
`endif
      end else begin
         disp_valid <= bus.disp_re;
         // Remembering the driven address lets an idle port hold it.
         last_addr  <= mem_addr;
         swap_ack   <= swap_now;

         if (swap_now) begin
            front_bank <= ~front_bank;
            state      <= POST_SWAP;
         end else begin
            case (state)
               ST_WRITE: begin
                  // swap_req with frame_end is handled by swap_now above;
                  // frame_end alone is ignored here.
                  if (bus.swap_req && !swap_ack) begin
                     state <= ST_PENDING;
                  end
               end

               ST_PENDING: begin
                  // Waits for frame_end; the swap itself is in swap_now.
               end

`ifdef FB_ARB_CLEAR_EN
               ST_CLEAR: begin
                  if (clr_we) begin
                     clr_cnt <= clr_cnt + 1'b1;
                     // Counter wraps to 0 on the last word, ready for the
                     // next clear.
                     if (clr_cnt == CLR_LAST) begin
                        state <= ST_WRITE;
                     end
                  end
               end
`endif

               default: begin
                  state <= ST_WRITE;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.disp_data  = bus.mem_rdata;
   assign bus.disp_valid = disp_valid;
   assign bus.wr_gnt     = wr_gnt;
   assign bus.swap_ack   = swap_ack;
   assign bus.front_bank = front_bank;
   assign bus.mem_addr   = mem_addr;
   assign bus.mem_we     = mem_we;
   assign bus.mem_wdata  = mem_wdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_arbiter
//
// Purpose:
//   Self-checking bench for fb_arbiter. A behavioural single-port RAM with a
//   one-cycle synchronous read sits on the RAM side; unwritten words read as a
//   fixed address-derived pattern. Display reads push their expected data to a
//   queue when issued and the queue is popped when disp_valid comes back.
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   between edges. Define FB_ARB_CLEAR_EN to exercise the clear phase.
// -----------------------------------------------------------------------------
module tb_fb_arbiter;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 24;
   localparam int WORDS  = 2 ** (ADDR_W + 1);

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Contents of a never-written word; bank0[5] is the word the read test uses.
   function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W:0] a);
      if (a == 11'h005) return 24'hABC123;
      return {2'b10, a, a};
   endfunction

   logic [DATA_W-1:0] ram     [0:WORDS-1];
   bit                written [0:WORDS-1];

   always @(posedge clk) begin
      if (bus.mem_we) begin
         ram[bus.mem_addr]     <= bus.mem_wdata;
         written[bus.mem_addr] <= 1'b1;
      end
      bus.mem_rdata <= written[bus.mem_addr] ? ram[bus.mem_addr] : pat(bus.mem_addr);
   end

   int n_cmp = 0;
   int n_err = 0;
   logic [DATA_W-1:0] exp_q [$];

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.disp_re   = 1'b0;
      bus.disp_addr = '0;
      bus.frame_end = 1'b0;
      bus.wr_req    = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.swap_req  = 1'b0;
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset();
      n_cmp++; if (bus.front_bank !== 1'b0) begin n_err++; $display("FAIL reset_front_bank: got %b want 0", bus.front_bank); end
      n_cmp++; if (bus.disp_valid !== 1'b0) begin n_err++; $display("FAIL reset_disp_valid: got %b want 0", bus.disp_valid); end
      n_cmp++; if (bus.swap_ack !== 1'b0)   begin n_err++; $display("FAIL reset_swap_ack: got %b want 0", bus.swap_ack); end
      #1;
      n_cmp++; if (bus.mem_we !== 1'b0)     begin n_err++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
      n_cmp++; if (bus.mem_addr !== 11'h0)  begin n_err++; $display("FAIL reset_mem_addr: got %h want 000", bus.mem_addr); end
      n_cmp++; if (bus.wr_gnt !== 1'b0)     begin n_err++; $display("FAIL reset_wr_gnt: got %b want 0", bus.wr_gnt); end
      rst = 1'b0;
      adv();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_read();
      logic [DATA_W-1:0] e;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            bus.disp_re   = 1'b1;
            bus.disp_addr = (i == 0) ? 10'd5 : 10'(20 + i);
            exp_q.push_back(pat({1'b0, bus.disp_addr}));
         end else begin
            bus.disp_re = 1'b0;
         end
         #1;
         if (i == 0) begin
            n_cmp++; if (bus.mem_addr !== 11'h005) begin n_err++; $display("FAIL read_mem_addr: got %h want 005", bus.mem_addr); end
            n_cmp++; if (bus.mem_we !== 1'b0)      begin n_err++; $display("FAIL read_mem_we: got %b want 0", bus.mem_we); end
         end
         adv();
         n_cmp++; if (bus.disp_valid !== (i < 5)) begin n_err++; $display("FAIL read_valid[%0d]: got %b want %b", i, bus.disp_valid, (i < 5)); end
         if (bus.disp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_err++; $display("FAIL read_sb_empty: got valid with no read outstanding");
            end else begin
               e = exp_q.pop_front();
               n_cmp++; if (bus.disp_data !== e) begin n_err++; $display("FAIL read_data[%0d]: got %h want %h", i, bus.disp_data, e); end
            end
         end
      end
      // Idle port holds the address of the last read (bank0, word 24).
      #1;
      n_cmp++; if (bus.mem_addr !== 11'h018) begin n_err++; $display("FAIL idle_hold_addr: got %h want 018", bus.mem_addr); end
      n_cmp++; if (bus.mem_we !== 1'b0)      begin n_err++; $display("FAIL idle_mem_we: got %b want 0", bus.mem_we); end
      adv();
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_write();
      logic [DATA_W-1:0] e;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 10'd7;
      bus.wr_data = 24'h00F0F0;
      #1;
      n_cmp++; if (bus.wr_gnt !== 1'b1)          begin n_err++; $display("FAIL write_gnt: got %b want 1", bus.wr_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b1)          begin n_err++; $display("FAIL write_mem_we: got %b want 1", bus.mem_we); end
      n_cmp++; if (bus.mem_addr !== 11'h407)     begin n_err++; $display("FAIL write_mem_addr: got %h want 407", bus.mem_addr); end
      n_cmp++; if (bus.mem_wdata !== 24'h00F0F0) begin n_err++; $display("FAIL write_wdata: got %h want 00f0f0", bus.mem_wdata); end
      adv();
      // Same request with the display reading: read wins.
      bus.disp_re   = 1'b1;
      bus.disp_addr = 10'd7;
      exp_q.push_back(pat(11'h007));
      #1;
      n_cmp++; if (bus.wr_gnt !== 1'b0)      begin n_err++; $display("FAIL write_blocked_gnt: got %b want 0", bus.wr_gnt); end
      n_cmp++; if (bus.mem_we !== 1'b0)      begin n_err++; $display("FAIL write_blocked_we: got %b want 0", bus.mem_we); end
      n_cmp++; if (bus.mem_addr !== 11'h007) begin n_err++; $display("FAIL write_blocked_addr: got %h want 007", bus.mem_addr); end
      adv();
      bus.disp_re = 1'b0;
      bus.wr_req  = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (bus.disp_data !== e) begin n_err++; $display("FAIL write_blocked_read: got %h want %h", bus.disp_data, e); end
      #1;
      n_cmp++; if (bus.wr_gnt !== 1'b0) begin n_err++; $display("FAIL no_req_gnt: got %b want 0", bus.wr_gnt); end
      adv();
   endtask

   // ---------------------------------------------------------------------------
`ifdef FB_ARB_CLEAR_EN
   // Entered in the swap_ack cycle of a swap to bank1; bank0 gets cleared
   // while the display reads on alternate cycles.
   task automatic test_clear();
      logic [DATA_W-1:0] e;
      int n_wr    = 0;
      int gnt_cyc = -1;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 10'd9;
      bus.wr_data = 24'h123456;
      for (int cyc = 0; cyc < 2200 && gnt_cyc < 0; cyc++) begin
         bus.disp_re   = ((cyc % 2) == 0) && (n_wr < 1024);
         bus.disp_addr = 10'(100 + (cyc / 2) % 50);
         if (bus.disp_re) exp_q.push_back(pat({1'b1, bus.disp_addr}));
         #1;
         if (bus.wr_gnt === 1'b1) begin
            gnt_cyc = cyc;
            n_cmp++; if (bus.mem_addr !== 11'h009) begin n_err++; $display("FAIL clear_post_addr: got %h want 009", bus.mem_addr); end
         end else if (bus.disp_re) begin
            n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL clear_read_we[%0d]: got %b want 0", cyc, bus.mem_we); end
         end else if (bus.mem_we === 1'b1) begin
            n_cmp++; if (bus.mem_addr !== {1'b0, 10'(n_wr)}) begin n_err++; $display("FAIL clear_addr[%0d]: got %h want %h", n_wr, bus.mem_addr, {1'b0, 10'(n_wr)}); end
            n_cmp++; if (bus.mem_wdata !== '0) begin n_err++; $display("FAIL clear_data[%0d]: got %h want 0", n_wr, bus.mem_wdata); end
            n_wr++;
         end
         adv();
         if (cyc == 0) begin
            n_cmp++; if (bus.swap_ack !== 1'b0) begin n_err++; $display("FAIL swap_ack_width: got %b want 0", bus.swap_ack); end
         end
         if (bus.disp_valid === 1'b1) begin
            e = exp_q.pop_front();
            n_cmp++; if (bus.disp_data !== e) begin n_err++; $display("FAIL clear_read_data: got %h want %h", bus.disp_data, e); end
         end
      end
      n_cmp++; if (n_wr != 1024)    begin n_err++; $display("FAIL clear_words: got %0d want 1024", n_wr); end
      n_cmp++; if (gnt_cyc != 2048) begin n_err++; $display("FAIL clear_duration: got %0d want 2048", gnt_cyc); end
      bus.disp_re = 1'b0;
      bus.wr_req  = 1'b0;
   endtask

   // Drains a clear with the port otherwise idle and a write waiting.
   task automatic drain_clear(input logic [ADDR_W:0] first_addr);
      int gnt_cyc = -1;
      bus.wr_req  = 1'b1;
      bus.wr_addr = 10'd3;
      bus.wr_data = 24'h000333;
      for (int cyc = 0; cyc < 1100 && gnt_cyc < 0; cyc++) begin
         #1;
         if (cyc == 0) begin
            n_cmp++; if (bus.mem_addr !== first_addr) begin n_err++; $display("FAIL drain_first_addr: got %h want %h", bus.mem_addr, first_addr); end
         end
         if (bus.wr_gnt === 1'b1) gnt_cyc = cyc;
         adv();
      end
      n_cmp++; if (gnt_cyc != 1024) begin n_err++; $display("FAIL drain_duration: got %0d want 1024", gnt_cyc); end
      bus.wr_req = 1'b0;
   endtask
`endif

   // ---------------------------------------------------------------------------
   task automatic test_swap_pending();
      logic [DATA_W-1:0] e;
      bus.swap_req = 1'b1;
      adv();
      bus.wr_req  = 1'b1;
      bus.wr_addr = 10'd9;
      bus.wr_data = 24'h123456;
      for (int i = 0; i < 20; i++) begin
         #1;
         n_cmp++; if (bus.wr_gnt !== 1'b0) begin n_err++; $display("FAIL pending_gnt[%0d]: got %b want 0", i, bus.wr_gnt); end
         adv();
      end
      n_cmp++; if (bus.front_bank !== 1'b0) begin n_err++; $display("FAIL pending_bank: got %b want 0", bus.front_bank); end
      // frame_end cycle with a read: the read still targets the old bank.
      bus.frame_end = 1'b1;
      bus.disp_re   = 1'b1;
      bus.disp_addr = 10'd7;
      exp_q.push_back(pat(11'h007));
      #1;
      n_cmp++; if (bus.mem_addr !== 11'h007) begin n_err++; $display("FAIL swap_edge_read_addr: got %h want 007", bus.mem_addr); end
      adv();
      bus.frame_end = 1'b0;
      bus.disp_re   = 1'b0;
      bus.swap_req  = 1'b0;
      n_cmp++; if (bus.front_bank !== 1'b1) begin n_err++; $display("FAIL swap_bank: got %b want 1", bus.front_bank); end
      n_cmp++; if (bus.swap_ack !== 1'b1)   begin n_err++; $display("FAIL swap_ack: got %b want 1", bus.swap_ack); end
      e = exp_q.pop_front();
      n_cmp++; if (bus.disp_data !== e)     begin n_err++; $display("FAIL swap_edge_read_data: got %h want %h", bus.disp_data, e); end
`ifdef FB_ARB_CLEAR_EN
      test_clear();
`else
      #1;
      n_cmp++; if (bus.wr_gnt !== 1'b1)      begin n_err++; $display("FAIL post_swap_gnt: got %b want 1", bus.wr_gnt); end
      n_cmp++; if (bus.mem_addr !== 11'h009) begin n_err++; $display("FAIL post_swap_addr: got %h want 009", bus.mem_addr); end
      adv();
      bus.wr_req = 1'b0;
      n_cmp++; if (bus.swap_ack !== 1'b0)    begin n_err++; $display("FAIL swap_ack_width: got %b want 0", bus.swap_ack); end
`endif
      // New front bank1 shows what was written to the back bank earlier.
      bus.disp_re   = 1'b1;
      bus.disp_addr = 10'd7;
      exp_q.push_back(24'h00F0F0);
      adv();
      bus.disp_re = 1'b0;
      e = exp_q.pop_front();
      n_cmp++; if (bus.disp_data !== e) begin n_err++; $display("FAIL front_read_data: got %h want %h", bus.disp_data, e); end
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_same_cycle_swap();
      // frame_end without swap_req is ignored in WRITE.
      bus.frame_end = 1'b1;
      adv();
      bus.frame_end = 1'b0;
      n_cmp++; if (bus.front_bank !== 1'b1) begin n_err++; $display("FAIL lone_frame_end_bank: got %b want 1", bus.front_bank); end
      n_cmp++; if (bus.swap_ack !== 1'b0)   begin n_err++; $display("FAIL lone_frame_end_ack: got %b want 0", bus.swap_ack); end
      bus.swap_req  = 1'b1;
      bus.frame_end = 1'b1;
      adv();
      bus.swap_req  = 1'b0;
      bus.frame_end = 1'b0;
      n_cmp++; if (bus.front_bank !== 1'b0) begin n_err++; $display("FAIL immediate_swap_bank: got %b want 0", bus.front_bank); end
      n_cmp++; if (bus.swap_ack !== 1'b1)   begin n_err++; $display("FAIL immediate_swap_ack: got %b want 1", bus.swap_ack); end
`ifdef FB_ARB_CLEAR_EN
      drain_clear(11'h400);
`else
      bus.wr_req  = 1'b1;
      bus.wr_addr = 10'd3;
      bus.wr_data = 24'h000333;
      #1;
      n_cmp++; if (bus.wr_gnt !== 1'b1)      begin n_err++; $display("FAIL immediate_gnt: got %b want 1", bus.wr_gnt); end
      n_cmp++; if (bus.mem_addr !== 11'h403) begin n_err++; $display("FAIL immediate_addr: got %h want 403", bus.mem_addr); end
      adv();
      bus.wr_req = 1'b0;
`endif
   endtask

   // ---------------------------------------------------------------------------
   task automatic test_reset_mid();
      bus.swap_req  = 1'b1;
      bus.frame_end = 1'b1;
      adv();
      bus.swap_req  = 1'b0;
      bus.frame_end = 1'b0;
      n_cmp++; if (bus.front_bank !== 1'b1) begin n_err++; $display("FAIL mid_setup_bank: got %b want 1", bus.front_bank); end
`ifdef FB_ARB_CLEAR_EN
      begin
         int n_wr = 0;
         for (int cyc = 0; cyc < 400 && n_wr < 300; cyc++) begin
            #1;
            if (bus.mem_we === 1'b1) n_wr++;
            adv();
         end
         n_cmp++; if (n_wr != 300) begin n_err++; $display("FAIL mid_clear_reach: got %0d want 300", n_wr); end
      end
`else
      adv();
      bus.swap_req = 1'b1;
      adv();
      bus.wr_req  = 1'b1;
      bus.wr_addr = 10'd11;
      #1;
      n_cmp++; if (bus.wr_gnt !== 1'b0) begin n_err++; $display("FAIL mid_pending_gnt: got %b want 0", bus.wr_gnt); end
      adv();
      bus.wr_req = 1'b0;
`endif
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL mid_reset_we: got %b want 0", bus.mem_we); end
      adv();
      rst          = 1'b0;
      bus.swap_req = 1'b0;
      n_cmp++; if (bus.front_bank !== 1'b0) begin n_err++; $display("FAIL mid_reset_bank: got %b want 0", bus.front_bank); end
      bus.wr_req  = 1'b1;
      bus.wr_addr = 10'd11;
      bus.wr_data = 24'h0000BB;
      #1;
      n_cmp++; if (bus.wr_gnt !== 1'b1)      begin n_err++; $display("FAIL mid_after_gnt: got %b want 1", bus.wr_gnt); end
      n_cmp++; if (bus.mem_addr !== 11'h40B) begin n_err++; $display("FAIL mid_after_addr: got %h want 40b", bus.mem_addr); end
      adv();
      bus.wr_req    = 1'b0;
      bus.frame_end = 1'b1;
      adv();
      bus.frame_end = 1'b0;
      n_cmp++; if (bus.front_bank !== 1'b0) begin n_err++; $display("FAIL mid_no_swap_bank: got %b want 0", bus.front_bank); end
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if (bus.mem_we !== 1'b0) begin n_err++; $display("FAIL mid_quiet_we[%0d]: got %b want 0", i, bus.mem_we); end
         adv();
      end
   endtask

   // ---------------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) adv();
      test_reset();
      test_read();
      test_write();
      test_swap_pending();
      test_same_cycle_swap();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL sb_leftover: got %0d outstanding reads want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
